// File: rtl/router12_sched_pkg.sv
// Shared types and constants for the 3-port tree-router grant scheduler.
// Holds the per-merge state encoding and the source-to-output request bit mapping.
package router12_sched_pkg;

  // Encoding doubles as the one-hot merge select driven to the datapath.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10
  } arb_state_t;

  localparam int OUT_P  = 0;
  localparam int OUT_C1 = 1;
  localparam int OUT_C2 = 2;

  // Bit position inside each source's sel vector that targets a given output.
  localparam int C1_TO_C2OUT = 0;
  localparam int C1_TO_POUT  = 1;
  localparam int C2_TO_C1OUT = 0;
  localparam int C2_TO_POUT  = 1;
  localparam int P_TO_C1OUT  = 0;
  localparam int P_TO_C2OUT  = 1;

  function automatic arb_state_t arbitrate(input logic [1:0] req, input logic rr);
    arb_state_t s;
    case (req)
      2'b01:   s = G0;
      2'b10:   s = G1;
      2'b11:   s = rr ? G1 : G0;
      default: s = IDLE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/router12_merge_arb.sv
// One output merge: round-robin grant FSM that holds a grant for a whole packet,
// plus a saturating hold counter that flags grants stuck without a tail.
module router12_merge_arb
  import router12_sched_pkg::*;
#(
  parameter int MAX_HOLD = 64
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] req,
  input  logic       done,
  output logic [1:0] grant,
  output logic       timeout,
  output logic       err_done
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam int CNT_W  = (HOLD_W < 1) ? 1 : HOLD_W;
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

  arb_state_t       state, state_nxt;
  logic             rr, rr_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_nxt;
  logic             timeout_r;

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr;
    case (state)
      IDLE: state_nxt = arbitrate(req, rr);
      G0, G1: begin
        // Tail seen: hand preference to the other input, then re-arbitrate
        // this cycle's requests so back-to-back packets lose no cycle.
        if (done) begin
          rr_nxt    = (state == G0);
          state_nxt = arbitrate(req, rr_nxt);
        end
      end
      default: state_nxt = IDLE;
    endcase

    hold_nxt = hold_cnt;
    if (state == IDLE || done || state_nxt != state)
      hold_nxt = '0;
    else if (hold_cnt != HOLD_MAX)
      hold_nxt = hold_cnt + CNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      rr        <= 1'b0;
      hold_cnt  <= '0;
      timeout_r <= 1'b0;
    end else begin
      state    <= state_nxt;
      rr       <= rr_nxt;
      hold_cnt <= hold_nxt;
      // Sticky flag only; the grant is never pulled mid-packet.
      if (MAX_HOLD != 0 && hold_nxt == HOLD_MAX)
        timeout_r <= 1'b1;
    end
  end

  assign grant    = state;
  assign timeout  = timeout_r;
  assign err_done = (state == IDLE) && done;

endmodule

// File: rtl/router12_grant_sched.sv
// Grant scheduler for a 3-port tree router: maps per-source selects onto the
// three output merges, screens illegal selects and gathers sticky error status.
module router12_grant_sched
  import router12_sched_pkg::*;
#(
  parameter int MAX_HOLD = 64
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] c1_sel,
  input  logic [1:0] c2_sel,
  input  logic [1:0] p_sel,
  input  logic       pout_done,
  input  logic       c1out_done,
  input  logic       c2out_done,
  output logic [1:0] pout_grant,
  output logic [1:0] c1out_grant,
  output logic [1:0] c2out_grant,
  output logic [2:0] timeout,
  output logic       err
);

  logic       c1_bad, c2_bad, p_bad;
  logic [1:0] c1_req, c2_req, p_req;
  logic [1:0] pout_req, c1out_req, c2out_req;
  logic [2:0] err_done;
  logic       err_r;

  // A source driving both select bits is malformed and requests nothing.
  assign c1_bad = (c1_sel == 2'b11);
  assign c2_bad = (c2_sel == 2'b11);
  assign p_bad  = (p_sel  == 2'b11);
  assign c1_req = c1_bad ? 2'b00 : c1_sel;
  assign c2_req = c2_bad ? 2'b00 : c2_sel;
  assign p_req  = p_bad  ? 2'b00 : p_sel;

  assign pout_req  = {c2_req[C2_TO_POUT], c1_req[C1_TO_POUT]};
  assign c1out_req = {p_req[P_TO_C1OUT],  c2_req[C2_TO_C1OUT]};
  assign c2out_req = {p_req[P_TO_C2OUT],  c1_req[C1_TO_C2OUT]};

  router12_merge_arb #(.MAX_HOLD(MAX_HOLD)) u_pout_arb (
    .CLK      (CLK),
    .RESET    (RESET),
    .req      (pout_req),
    .done     (pout_done),
    .grant    (pout_grant),
    .timeout  (timeout[OUT_P]),
    .err_done (err_done[OUT_P])
  );

  router12_merge_arb #(.MAX_HOLD(MAX_HOLD)) u_c1out_arb (
    .CLK      (CLK),
    .RESET    (RESET),
    .req      (c1out_req),
    .done     (c1out_done),
    .grant    (c1out_grant),
    .timeout  (timeout[OUT_C1]),
    .err_done (err_done[OUT_C1])
  );

  router12_merge_arb #(.MAX_HOLD(MAX_HOLD)) u_c2out_arb (
    .CLK      (CLK),
    .RESET    (RESET),
    .req      (c2out_req),
    .done     (c2out_done),
    .grant    (c2out_grant),
    .timeout  (timeout[OUT_C2]),
    .err_done (err_done[OUT_C2])
  );

  always_ff @(posedge CLK) begin
    if (RESET)
      err_r <= 1'b0;
    else if (c1_bad || c2_bad || p_bad || (|err_done))
      err_r <= 1'b1;
  end

  assign err = err_r;

endmodule

// File: tb/tb_router12_grant_sched.sv
// Directed bench for router12_grant_sched: a vector table for the main grant
// sequences plus hand-written timeout and mid-packet reset sequences.
module tb_router12_grant_sched;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [1:0] c1_sel, c2_sel, p_sel;
  logic       pout_done, c1out_done, c2out_done;
  logic [1:0] pout_grant, c1out_grant, c2out_grant;
  logic [2:0] timeout;
  logic       err;
  logic [1:0] pout_grant_h, c1out_grant_h, c2out_grant_h;
  logic [2:0] timeout_h;
  logic       err_h;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  router12_grant_sched dut (
    .CLK(CLK), .RESET(RESET),
    .c1_sel(c1_sel), .c2_sel(c2_sel), .p_sel(p_sel),
    .pout_done(pout_done), .c1out_done(c1out_done), .c2out_done(c2out_done),
    .pout_grant(pout_grant), .c1out_grant(c1out_grant), .c2out_grant(c2out_grant),
    .timeout(timeout), .err(err)
  );

  // Short hold limit so the stuck-grant detector can be exercised quickly.
  router12_grant_sched #(.MAX_HOLD(4)) dut_h4 (
    .CLK(CLK), .RESET(RESET),
    .c1_sel(c1_sel), .c2_sel(c2_sel), .p_sel(p_sel),
    .pout_done(pout_done), .c1out_done(c1out_done), .c2out_done(c2out_done),
    .pout_grant(pout_grant_h), .c1out_grant(c1out_grant_h), .c2out_grant(c2out_grant_h),
    .timeout(timeout_h), .err(err_h)
  );

  typedef struct {
    logic       rst;
    logic [1:0] c1, c2, p;
    logic       pd, c1d, c2d;
    logic [1:0] pg, c1g, c2g;
    logic [2:0] to;
    logic       er;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs[NV];

  task automatic chk(input string name, input int idx, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%0h expected=%0h", name, idx, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic [1:0] c1, input logic [1:0] c2, input logic [1:0] p,
                      input logic pd, input logic c1d, input logic c2d);
    RESET = r; c1_sel = c1; c2_sel = c2; p_sel = p;
    pout_done = pd; c1out_done = c1d; c2out_done = c2d;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET = 1'b1; c1_sel = 2'b00; c2_sel = 2'b00; p_sel = 2'b00;
    pout_done = 1'b0; c1out_done = 1'b0; c2out_done = 1'b0;

    //           rst  c1     c2     p      pd  c1d c2d  pg     c1g    c2g    to      err
    vecs[0]  = '{1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
    // single C1 packet to Pout
    vecs[1]  = '{1'b0, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 3'b000, 1'b0};
    vecs[2]  = '{1'b0, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 3'b000, 1'b0};
    vecs[3]  = '{1'b0, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 3'b000, 1'b0};
    vecs[4]  = '{1'b0, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 3'b000, 1'b0};
    vecs[5]  = '{1'b0, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 3'b000, 1'b0};
    vecs[6]  = '{1'b0, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 3'b000, 1'b0};
    vecs[7]  = '{1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
    // reset so Pout rr is back at 0, then contention C1 vs C2
    vecs[8]  = '{1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
    vecs[9]  = '{1'b0, 2'b10, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 3'b000, 1'b0};
    vecs[10] = '{1'b0, 2'b10, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 3'b000, 1'b0};
    vecs[11] = '{1'b0, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 3'b000, 1'b0};
    vecs[12] = '{1'b0, 2'b00, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 3'b000, 1'b0};
    vecs[13] = '{1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 3'b000, 1'b0};
    vecs[14] = '{1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
    // C1out and C2out granted together, simultaneous dones
    vecs[15] = '{1'b0, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, 1'b0};
    vecs[16] = '{1'b0, 2'b01, 2'b01, 2'b01, 1'b0, 1'b1, 1'b1, 2'b00, 2'b10, 2'b01, 3'b000, 1'b0};
    vecs[17] = '{1'b0, 2'b01, 2'b00, 2'b10, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 2'b10, 3'b000, 1'b0};
    vecs[18] = '{1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
    // illegal select, then done while idle
    vecs[19] = '{1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1};
    vecs[20] = '{1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1};
    vecs[21] = '{1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 3'b000, 1'b1};
    vecs[22] = '{1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};

    @(negedge CLK);
    for (int i = 0; i < NV; i++) begin
      step(vecs[i].rst, vecs[i].c1, vecs[i].c2, vecs[i].p, vecs[i].pd, vecs[i].c1d, vecs[i].c2d);
      chk("pout_grant",  i, {6'd0, pout_grant},  {6'd0, vecs[i].pg});
      chk("c1out_grant", i, {6'd0, c1out_grant}, {6'd0, vecs[i].c1g});
      chk("c2out_grant", i, {6'd0, c2out_grant}, {6'd0, vecs[i].c2g});
      chk("timeout",     i, {5'd0, timeout},     {5'd0, vecs[i].to});
      chk("err",         i, {7'd0, err},         {7'd0, vecs[i].er});
    end

    // Hold timeout with MAX_HOLD=4: C2 granted on C1out, request dropped, no tail.
    step(1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("h4_c1out_grant", 100, {6'd0, c1out_grant_h}, 8'h01);
    for (int k = 1; k <= 3; k++) begin
      step(1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
      chk("h4_timeout_early", 100 + k, {5'd0, timeout_h}, 8'h00);
    end
    step(1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("h4_timeout_set", 104, {5'd0, timeout_h}, 8'h02);
    chk("h4_grant_kept", 104, {6'd0, c1out_grant_h}, 8'h01);
    chk("default_no_timeout", 104, {5'd0, timeout}, 8'h00);
    step(1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("h4_grant_kept2", 105, {6'd0, c1out_grant_h}, 8'h01);
    step(1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    chk("h4_grant_released", 106, {6'd0, c1out_grant_h}, 8'h00);
    chk("h4_timeout_sticky", 106, {5'd0, timeout_h}, 8'h02);

    // Mid-packet reset with Pout granted to C2, timeout and err both set.
    step(1'b0, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("h4_pout_c2", 107, {6'd0, pout_grant_h}, 8'h02);
    step(1'b0, 2'b11, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("h4_pre_rst_timeout", 111, {5'd0, timeout_h}, 8'h03);
    chk("h4_pre_rst_err", 111, {7'd0, err_h}, 8'h01);
    chk("h4_pre_rst_grant", 111, {6'd0, pout_grant_h}, 8'h02);
    step(1'b1, 2'b10, 2'b10, 2'b01, 1'b1, 1'b0, 1'b0);
    chk("rst_pout_grant", 112, {6'd0, pout_grant_h}, 8'h00);
    chk("rst_c1out_grant", 112, {6'd0, c1out_grant_h}, 8'h00);
    chk("rst_timeout", 112, {5'd0, timeout_h}, 8'h00);
    chk("rst_err", 112, {7'd0, err_h}, 8'h00);
    step(1'b0, 2'b10, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("post_rst_rr0", 113, {6'd0, pout_grant_h}, 8'h01);
    chk("post_rst_rr0_main", 113, {6'd0, pout_grant}, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/router12_grant_sched.md
Name: router12_grant_sched

Overview:
- Clocked scheduler that generates the merge grant selects for a 3-port tree router (child C1, child C2, parent P).
- Each output merge (Pout, C1out, C2out) has two candidate inputs. The block collects per-input routing selects, arbitrates round-robin per output, and holds each grant for a whole packet until the merge reports the tail transfer.
- Also watches for stuck grants and illegal selects.

Parameters:
- MAX_HOLD, 64, cycles a grant may stay held without a done pulse before that output's timeout flag sets. 0 disables the check.
- HOLD_W, $clog2(MAX_HOLD+1), hold-counter width. Derived, not overridden.

Ports:
- CLK  in  1  clock. All state updates on posedge.
- RESET  in  1  synchronous, active-high reset.
- c1_sel  in  2  C1 input request: bit0 = to C2out, bit1 = to Pout. One-hot or zero.
- c2_sel  in  2  C2 input request: bit0 = to C1out, bit1 = to Pout.
- p_sel  in  2  P input request: bit0 = to C1out, bit1 = to C2out.
- pout_done  in  1  pulse: tail flit transferred through Pout merge.
- c1out_done  in  1  pulse: tail flit transferred through C1out merge.
- c2out_done  in  1  pulse: tail flit transferred through C2out merge.
- pout_grant  out  2  one-hot merge select: bit0 = C1, bit1 = C2.
- c1out_grant  out  2  bit0 = C2, bit1 = P.
- c2out_grant  out  2  bit0 = C1, bit1 = P.
- timeout  out  3  sticky per-output hold timeout: [0] Pout, [1] C1out, [2] C2out.
- err  out  1  sticky protocol error.

Behaviour:
- Request mapping:
  - Pout: req0 = c1_sel[1], req1 = c2_sel[1].
  - C1out: req0 = c2_sel[0], req1 = p_sel[0].
  - C2out: req0 = c1_sel[0], req1 = p_sel[1].
- A source whose sel equals 2'b11:
  - contributes no requests that cycle;
  - sets err.
- Per-output FSM states IDLE, G0, G1. Grant output = 00 / 01 / 10 respectively, driven straight from the state register (registered outputs).
- The round-robin pointer rr names the preferred input; it resets to 0.
- IDLE:
  - only req0 → G0; only req1 → G1.
  - both → G[rr].
  - none → stay IDLE.
- Gk, done=0: stay Gk. A request drop while granted does not revoke the grant.
- Gk, done=1:
  - rr := ~k.
  - Next state re-arbitrates the current cycle's requests with the updated rr: other input requesting → G(~k); else own input requesting → Gk (back-to-back, no bubble); else → IDLE.
- Latency:
  - request to grant = 1 cycle;
  - done to next grant = 1 cycle (zero idle cycles between packets).
- done while IDLE: ignored for state; sets err.
- Hold counter per output:
  - clears on any state change and in IDLE;
  - increments each cycle in Gk with done=0;
  - saturates at MAX_HOLD.
  - When it reaches MAX_HOLD (and MAX_HOLD≠0), the matching timeout bit sets.
  - Timeout never revokes a grant, to keep packet integrity.
- Outputs are independent: the same source may hold grants on two outputs at once only if its sel changes between packets. The scheduler does not enforce source exclusivity.
- RESET (any cycle, including mid-packet) forces, on the next edge: all FSMs IDLE, grants 00, rr 0, counters 0, timeout 000, err 0. Inputs are ignored during RESET.

Decomposition:
- Package router12_sched_pkg holds:
  - state enum {IDLE, G0, G1};
  - output index constants OUT_P = 0, OUT_C1 = 1, OUT_C2 = 2;
  - source-to-output mapping constants.
- Sub-module router12_merge_arb holds one output's FSM, rr pointer and hold counter. Its ports: CLK, RESET, req[1:0], done, grant[1:0], timeout, err_done.
- Top instantiates it three times and adds request mapping, 11-detection and err OR-ing.

Test Plan:
- Reset, then c1_sel=10 held → cycle 1 pout_grant=01; hold 5 cycles, pout_done pulse → next cycle pout_grant=00; timeout=000, err=0.
- c1_sel=10 and c2_sel=10 together from IDLE (rr=0) → pout_grant=01. On pout_done → 10 the next cycle with no IDLE cycle. Done again with only C2 requesting → 10 again.
- p_sel=01 and c2_sel=01, plus c1_sel=01 and p_sel stays 01 (only one P select legal, so use p_sel=10 for C2out):
  - c1out_grant=01 and c2out_grant=01 granted in the same cycle;
  - dones in the same cycle → each switches to its req1 if pending.
- MAX_HOLD=4, c2_sel=01 granted, no done → timeout[1]=1 exactly 4 cycles after the grant. Grant stays 01 and timeout stays set after done.
- c1_sel=11 → no grants change, err=1. c2out_done pulse while C2out IDLE → err stays 1, c2out_grant=00.
- Mid-packet RESET with pout_grant=10 and timeout set → next cycle all grants 00, timeout=000, err=0. After release, c1_sel=10 → pout_grant=01 (rr back at 0).
